// File: rtl/led_sram_arbiter.sv
// led_sram_arbiter: shares one single-port frame SRAM between a single-word
// pixel write path and a 16-word scan-line fetch path. Reads win arbitration,
// but a pending write is granted after STARVE_LIMIT consecutive bursts have
// been granted over it.
//
// Handshake: a requester raises wr_req/rd_req with its payload and holds both
// stable until the matching one-cycle ack pulse; the payload is sampled on the
// clock edge that raises the ack. Fetched words stream out on rd_valid with no
// back-pressure: rd_idx gives the beat number and rd_done marks beat 15.
module led_sram_arbiter #(
  parameter int AW           = 9,
  parameter int DW           = 16,
  parameter int STARVE_LIMIT = 2
) (
  input  logic          GCK,
  input  logic          rst,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ack,
  input  logic          rd_req,
  input  logic [AW-5:0] rd_line,
  output logic          rd_ack,
  output logic          rd_valid,
  output logic [3:0]    rd_idx,
  output logic [DW-1:0] rd_data,
  output logic          rd_done,
  output logic          busy,
  output logic          sram_cen_n,
  output logic          sram_wen_n,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_d,
  input  logic [DW-1:0] sram_q
);

  localparam int CW = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, WRITE, RBURST, RDRAIN} state_t;

  state_t          state;
  state_t          next_state;
  logic            grant_wr;
  logic            grant_rd;
  logic [CW-1:0]   starve_cnt;
  logic [AW-5:0]   line_q;
  logic [3:0]      beat;
  logic [AW-1:0]   wr_addr_q;
  logic [DW-1:0]   wr_data_q;
  logic            rd_issue;
  logic [3:0]      issue_idx;

  // Next-state and grant decision; only IDLE ever grants.
  always_comb begin
    next_state = state;
    grant_wr   = 1'b0;
    grant_rd   = 1'b0;
    case (state)
      IDLE: begin
        if (wr_req && (starve_cnt >= LIMIT)) begin
          grant_wr   = 1'b1;
          next_state = WRITE;
        end else if (rd_req) begin
          grant_rd   = 1'b1;
          next_state = RBURST;
        end else if (wr_req) begin
          grant_wr   = 1'b1;
          next_state = WRITE;
        end
      end
      WRITE:   next_state = IDLE;
      RBURST:  if (beat == 4'hF) next_state = RDRAIN;
      RDRAIN:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge GCK) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Acks, payload capture, beat counter and starvation counter.
  always_ff @(posedge GCK) begin
    if (rst) begin
      wr_ack     <= 1'b0;
      rd_ack     <= 1'b0;
      busy       <= 1'b0;
      starve_cnt <= '0;
      line_q     <= '0;
      beat       <= 4'd0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      wr_ack <= grant_wr;
      rd_ack <= grant_rd;
      busy   <= (next_state != IDLE);
      if (grant_wr) begin
        wr_addr_q  <= wr_addr;
        wr_data_q  <= wr_data;
        starve_cnt <= '0;
      end
      if (grant_rd) begin
        line_q <= rd_line;
        beat   <= 4'd0;
        if (wr_req && (starve_cnt != LIMIT)) starve_cnt <= starve_cnt + CW'(1);
      end
      // beat 15 -> 0 rollover coincides with leaving RBURST
      if (state == RBURST) beat <= beat + 4'd1;
    end
  end

  // SRAM port drive; address and write data hold when the macro is idle.
  always_ff @(posedge GCK) begin
    if (rst) begin
      sram_cen_n <= 1'b1;
      sram_wen_n <= 1'b1;
      sram_addr  <= '0;
      sram_d     <= '0;
      rd_issue   <= 1'b0;
      issue_idx  <= 4'd0;
    end else begin
      rd_issue <= 1'b0;
      case (state)
        WRITE: begin
          sram_cen_n <= 1'b0;
          sram_wen_n <= 1'b0;
          sram_addr  <= wr_addr_q;
          sram_d     <= wr_data_q;
        end
        RBURST: begin
          sram_cen_n <= 1'b0;
          sram_wen_n <= 1'b1;
          sram_addr  <= {line_q, beat};
          rd_issue   <= 1'b1;
          issue_idx  <= beat;
        end
        default: begin
          sram_cen_n <= 1'b1;
          sram_wen_n <= 1'b1;
        end
      endcase
    end
  end

  // Read return tagging: one cycle behind the access, aligned with sram_q.
  always_ff @(posedge GCK) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_idx   <= 4'd0;
      rd_done  <= 1'b0;
    end else begin
      rd_valid <= rd_issue;
      rd_done  <= rd_issue && (issue_idx == 4'hF);
      if (rd_issue) rd_idx <= issue_idx;
    end
  end

  // The macro's q is already a registered output, so it is forwarded while
  // rd_valid is high and forced to zero otherwise (zero after reset too).
  assign rd_data = rd_valid ? sram_q : '0;

endmodule
